rx_slot_sched: RTL

- Schedules the RX packet-buffer slots between the GMII receive writer (ethpipe side) and the PCIe host in the clk_125 domain.
- Grants free slots to the receive writer in round-robin order.
- Queues filled slots in completion order for the host, and returns slots to the free pool on host release.
- Generates a coalesced host interrupt pulse.
- All ethernet-side handshakes arrive already synchronised into clk_125.

---
 rtl/rx_slot_pkg.sv | 25 ++
 rtl/slot_idx_fifo.sv | 56 +++++
 rtl/rx_slot_sched.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/rx_slot_pkg.sv
// ---------------------------------------------------------------
// rx_slot_pkg : shared slot-state and error-cause types for RX scheduling
// rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package rx_slot_pkg;

   typedef enum logic [1:0] {
      SLOT_FREE    = 2'd0,
      SLOT_FILLING = 2'd1,
      SLOT_READY   = 2'd2,
      SLOT_HOST    = 2'd3
   } slot_state_t;

   typedef enum logic [1:0] {
      ERR_NONE        = 2'd0,
      ERR_STRAY_FILL  = 2'd1,
      ERR_STRAY_POP   = 2'd2,
      ERR_BAD_RELEASE = 2'd3
   } err_cause_t;

endpackage

`default_nettype wire

// File: rtl/slot_idx_fifo.sv
// ---------------------------------------------------------------
// slot_idx_fifo : sync FIFO of {slot,len} with look-ahead head/count
// rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module slot_idx_fifo #(
   parameter int DEPTH  = 4,
   parameter int PTR_W  = 2,
   parameter int DATA_W = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [PTR_W:0]    count,
   output logic [PTR_W:0]    count_nxt,
   output logic [DATA_W-1:0] head_nxt
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr_nxt;
   logic [PTR_W:0]    after_pop;
   logic              do_pop;

   always_comb begin
      do_pop     = pop && (count != '0);
      rd_ptr_nxt = rd_ptr + PTR_W'(do_pop);
      after_pop  = count - (PTR_W+1)'(do_pop);
      count_nxt  = after_pop + (PTR_W+1)'(push);
      // a push into an otherwise-empty queue becomes the head directly
      head_nxt   = (after_pop == '0) ? push_data : mem[rd_ptr_nxt];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         rd_ptr <= rd_ptr_nxt;
         count  <= count_nxt;
      end
   end

endmodule

`default_nettype wire

// File: rtl/rx_slot_sched.sv
// ---------------------------------------------------------------
// rx_slot_sched : RX buffer slot scheduler between GMII writer and host
// rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module rx_slot_sched
   import rx_slot_pkg::*;
#(
   parameter int NUM_SLOTS   = 4,
   parameter int SLOT_W      = 2,
   parameter int LEN_W       = 12,
   parameter int IRQ_THRESH  = 4,
   parameter int IRQ_TIMEOUT = 1024
) (
   input  logic                 clk_125,
   input  logic                 sys_rst_n,
   input  logic                 fill_req,
   output logic                 fill_gnt,
   output logic [SLOT_W-1:0]    fill_slot,
   input  logic                 fill_done,
   input  logic [LEN_W-1:0]     fill_len,
   input  logic                 fill_abort,
   output logic                 host_valid,
   output logic [SLOT_W-1:0]    host_slot,
   output logic [LEN_W-1:0]     host_len,
   input  logic                 host_pop,
   input  logic                 host_release,
   input  logic [SLOT_W-1:0]    host_rel_slot,
   input  logic                 irq_en,
   output logic                 irq,
   output logic [NUM_SLOTS-1:0] empty_mask,
   output logic                 err_sticky
);

   localparam int CNT_W = $clog2(IRQ_THRESH + 1);
   localparam int TMR_W = $clog2(IRQ_TIMEOUT + 1);

   slot_state_t slot_q [NUM_SLOTS];
   slot_state_t slot_d [NUM_SLOTS];
   logic              filling_q;
   logic [SLOT_W-1:0] rr_q;
   logic [SLOT_W-1:0] cand;
   logic [SLOT_W-1:0] gnt_idx;
   logic              gnt_found;
   logic              do_grant, done_ok, abort_ok, pop_ok, rel_ok;
   err_cause_t        err_cause;
   logic [SLOT_W:0]   fifo_count, fifo_count_nxt;
   logic [SLOT_W+LEN_W-1:0] fifo_head_nxt;
   logic [CNT_W-1:0]  cnt_q, cnt_plus;
   logic [TMR_W-1:0]  tmr_q;
   logic              tmo, fire;

   // first FREE slot at or after rr_q; lowest offset wins
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
         cand = rr_q + SLOT_W'(k);
         if (slot_q[cand] == SLOT_FREE) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   always_comb begin
      do_grant = fill_req && !filling_q && gnt_found;
      done_ok  = fill_done && filling_q;
      abort_ok = fill_abort && filling_q && !fill_done;
      pop_ok   = host_pop && (fifo_count != '0);
      rel_ok   = host_release && (slot_q[host_rel_slot] == SLOT_HOST);

      err_cause = ERR_NONE;
      if ((fill_done || fill_abort) && !filling_q) err_cause = ERR_STRAY_FILL;
      else if (host_pop && (fifo_count == '0))     err_cause = ERR_STRAY_POP;
      else if (host_release && !rel_ok)            err_cause = ERR_BAD_RELEASE;

      for (int i = 0; i < NUM_SLOTS; i++) slot_d[i] = slot_q[i];
      if (do_grant) slot_d[gnt_idx]       = SLOT_FILLING;
      if (done_ok)  slot_d[fill_slot]     = SLOT_READY;
      if (abort_ok) slot_d[fill_slot]     = SLOT_FREE;
      if (pop_ok)   slot_d[host_slot]     = SLOT_HOST;
      if (rel_ok)   slot_d[host_rel_slot] = SLOT_FREE;
   end

   // with irq_en low the counter saturates and the timer parks at its
   // terminal value, so enabling later fires on the very next cycle
   always_comb begin
      cnt_plus = (done_ok && (cnt_q != CNT_W'(IRQ_THRESH))) ? cnt_q + CNT_W'(1) : cnt_q;
      tmo      = (cnt_q != '0) && (tmr_q == TMR_W'(IRQ_TIMEOUT - 1));
      fire     = irq_en && ((cnt_plus == CNT_W'(IRQ_THRESH)) || tmo);
   end

   slot_idx_fifo #(
      .DEPTH  (NUM_SLOTS),
      .PTR_W  (SLOT_W),
      .DATA_W (SLOT_W + LEN_W)
   ) u_fifo (
      .clk       (clk_125),
      .rst_n     (sys_rst_n),
      .push      (done_ok),
      .push_data ({fill_slot, fill_len}),
      .pop       (pop_ok),
      .count     (fifo_count),
      .count_nxt (fifo_count_nxt),
      .head_nxt  (fifo_head_nxt)
   );

   always_ff @(posedge clk_125) begin
      if (!sys_rst_n) begin
         for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= SLOT_FREE;
         filling_q  <= 1'b0;
         rr_q       <= '0;
         fill_gnt   <= 1'b0;
         fill_slot  <= '0;
         host_valid <= 1'b0;
         host_slot  <= '0;
         host_len   <= '0;
         err_sticky <= 1'b0;
         irq        <= 1'b0;
         cnt_q      <= '0;
         tmr_q      <= '0;
      end else begin
         slot_q   <= slot_d;
         fill_gnt <= do_grant;
         if (do_grant) begin
            fill_slot <= gnt_idx;
            rr_q      <= gnt_idx + SLOT_W'(1);
            filling_q <= 1'b1;
         end else if (done_ok || abort_ok) begin
            filling_q <= 1'b0;
         end
         host_valid <= (fifo_count_nxt != '0);
         if (fifo_count_nxt != '0) {host_slot, host_len} <= fifo_head_nxt;
         if (err_cause != ERR_NONE) err_sticky <= 1'b1;
         if (fire) begin
            irq   <= 1'b1;
            cnt_q <= '0;
            tmr_q <= '0;
         end else begin
            irq   <= 1'b0;
            cnt_q <= cnt_plus;
            if ((cnt_q != '0) && !tmo) tmr_q <= tmr_q + TMR_W'(1);
         end
      end
   end

   for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_mask
      assign empty_mask[i] = (slot_q[i] == SLOT_FREE);
   end

endmodule

`default_nettype wire
